// File: rtl/axi_uart_tx.sv
// AXI4-Lite stdout transmitter: a TX FIFO written over AXI4-Lite, drained by
// an 8N1 serializer running at CLK_FREQ / BAUD cycles per bit.
module axi_uart_tx #(
    parameter int unsigned CLK_FREQ   = 100_000_000,
    parameter int unsigned BAUD       = 57600,
    parameter int unsigned FIFO_DEPTH = 16
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        s_awvalid,
    output logic        s_awready,
    input  logic [31:0] s_awaddr,
    input  logic        s_wvalid,
    output logic        s_wready,
    input  logic [31:0] s_wdata,
    input  logic [3:0]  s_wstrb,
    output logic        s_bvalid,
    input  logic        s_bready,
    output logic [1:0]  s_bresp,
    input  logic        s_arvalid,
    output logic        s_arready,
    input  logic [31:0] s_araddr,
    output logic        s_rvalid,
    input  logic        s_rready,
    output logic [31:0] s_rdata,
    output logic [1:0]  s_rresp,
    output logic        tx_o,
    output logic        tx_empty_o
);

    localparam int unsigned DIV   = CLK_FREQ / BAUD;
    localparam int          CNT_W = $clog2(DIV);
    localparam int          AW    = $clog2(FIFO_DEPTH);
    localparam logic [CNT_W-1:0] BAUD_LAST  = CNT_W'(DIV - 1);
    localparam logic [AW:0]      FULL_COUNT = (AW+1)'(FIFO_DEPTH);
    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

    state_t           state, state_next;
    logic [CNT_W-1:0] baud_cnt, baud_next;
    logic [2:0]       bit_cnt, bit_next;
    logic [7:0]       shift, shift_next;
    logic             tx_next;

    logic [7:0]  mem [FIFO_DEPTH];
    logic [AW:0] wr_ptr, rd_ptr, count;
    logic        full, empty, push, pop, busy;
    logic [7:0]  fifo_head;

    logic        aw_hs, ar_hs;
    logic [1:0]  wr_resp, rd_resp;
    logic [31:0] rd_word;
    logic        unused_bits;

    assign unused_bits = ^{s_awaddr[31:4], s_awaddr[1:0], s_araddr[31:4],
                           s_araddr[1:0], s_wdata[31:8], s_wstrb[3:1]};

    // The wrap bit of each pointer lets a full FIFO differ from an empty one.
    assign count     = wr_ptr - rd_ptr;
    assign full      = (count == FULL_COUNT);
    assign empty     = (wr_ptr == rd_ptr);
    assign fifo_head = mem[rd_ptr[AW-1:0]];
    assign busy      = (state != IDLE);
    assign tx_empty_o = empty && !busy;

    assign aw_hs     = s_awvalid && s_wvalid && !s_bvalid;
    assign s_awready = aw_hs;
    assign s_wready  = aw_hs;
    assign ar_hs     = s_arvalid && !s_rvalid;
    assign s_arready = ar_hs;

    always_comb begin
        wr_resp = RESP_OKAY;
        push    = 1'b0;
        case (s_awaddr[3:2])
            2'd0: begin
                if (s_wstrb[0]) begin
                    if (full) wr_resp = RESP_SLVERR;
                    else      push    = aw_hs;
                end
            end
            2'd1:    wr_resp = RESP_OKAY;
            default: wr_resp = RESP_SLVERR;
        endcase
    end

    always_comb begin
        rd_word = '0;
        rd_resp = RESP_OKAY;
        case (s_araddr[3:2])
            2'd0:    rd_word = '0;
            2'd1:    rd_word = {15'd0, 9'(count), 5'd0, busy, empty, full};
            default: rd_resp = RESP_SLVERR;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s_bvalid <= 1'b0;
            s_bresp  <= RESP_OKAY;
            s_rvalid <= 1'b0;
            s_rresp  <= RESP_OKAY;
            s_rdata  <= '0;
        end else begin
            if (aw_hs) begin
                s_bvalid <= 1'b1;
                s_bresp  <= wr_resp;
            end else if (s_bready) begin
                s_bvalid <= 1'b0;
            end
            if (ar_hs) begin
                s_rvalid <= 1'b1;
                s_rresp  <= rd_resp;
                s_rdata  <= rd_word;
            end else if (s_rready) begin
                s_rvalid <= 1'b0;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr[AW-1:0]] <= s_wdata[7:0];
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            baud_cnt <= '0;
            bit_cnt  <= '0;
            shift    <= '0;
            tx_o     <= 1'b1;
        end else begin
            state    <= state_next;
            baud_cnt <= baud_next;
            bit_cnt  <= bit_next;
            shift    <= shift_next;
            tx_o     <= tx_next;
        end
    end

    // tx_next is the line level for the following cycle, so tx_o is a flop.
    always_comb begin
        state_next = state;
        baud_next  = baud_cnt;
        bit_next   = bit_cnt;
        shift_next = shift;
        tx_next    = tx_o;
        pop        = 1'b0;
        case (state)
            IDLE: begin
                baud_next = '0;
                bit_next  = '0;
                tx_next   = 1'b1;
                if (!empty) begin
                    pop        = 1'b1;
                    shift_next = fifo_head;
                    tx_next    = 1'b0;
                    state_next = START;
                end
            end
            START: begin
                if (baud_cnt == BAUD_LAST) begin
                    baud_next  = '0;
                    tx_next    = shift[0];
                    state_next = DATA;
                end else begin
                    baud_next = baud_cnt + 1'b1;
                end
            end
            DATA: begin
                if (baud_cnt == BAUD_LAST) begin
                    baud_next = '0;
                    if (bit_cnt == 3'd7) begin
                        bit_next   = '0;
                        tx_next    = 1'b1;
                        state_next = STOP;
                    end else begin
                        bit_next   = bit_cnt + 3'd1;
                        shift_next = shift >> 1;
                        tx_next    = shift[1];
                    end
                end else begin
                    baud_next = baud_cnt + 1'b1;
                end
            end
            STOP: begin
                if (baud_cnt == BAUD_LAST) begin
                    baud_next = '0;
                    if (!empty) begin
                        pop        = 1'b1;
                        shift_next = fifo_head;
                        tx_next    = 1'b0;
                        state_next = START;
                    end else begin
                        tx_next    = 1'b1;
                        state_next = IDLE;
                    end
                end else begin
                    baud_next = baud_cnt + 1'b1;
                end
            end
            default: state_next = IDLE;
        endcase
    end

endmodule

// File: tb/tb_axi_uart_tx.sv
// Bench for axi_uart_tx at DIV=10, FIFO_DEPTH=4: AXI drivers, a serial line
// monitor that checks frames against a queue of expected bytes, and scenario tasks.
module tb_axi_uart_tx;

    localparam int DIV = 10;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        s_awvalid = 1'b0, s_wvalid = 1'b0, s_bready = 1'b1;
    logic        s_arvalid = 1'b0, s_rready = 1'b1;
    logic [31:0] s_awaddr = '0, s_wdata = '0, s_araddr = '0;
    logic [3:0]  s_wstrb = '0;
    logic        s_awready, s_wready, s_bvalid, s_arready, s_rvalid;
    logic [1:0]  s_bresp, s_rresp;
    logic [31:0] s_rdata;
    logic        tx_o, tx_empty_o;

    int n_cmp = 0;
    int n_err = 0;
    int cyc = 0;
    int frames_started = 0;
    int frames_done = 0;
    int last_end = 0;
    logic [7:0] exp_q[$];

    axi_uart_tx #(.CLK_FREQ(1_000_000), .BAUD(100_000), .FIFO_DEPTH(4)) dut (
        .clk(clk), .rst_n(rst_n),
        .s_awvalid(s_awvalid), .s_awready(s_awready), .s_awaddr(s_awaddr),
        .s_wvalid(s_wvalid), .s_wready(s_wready), .s_wdata(s_wdata), .s_wstrb(s_wstrb),
        .s_bvalid(s_bvalid), .s_bready(s_bready), .s_bresp(s_bresp),
        .s_arvalid(s_arvalid), .s_arready(s_arready), .s_araddr(s_araddr),
        .s_rvalid(s_rvalid), .s_rready(s_rready), .s_rdata(s_rdata), .s_rresp(s_rresp),
        .tx_o(tx_o), .tx_empty_o(tx_empty_o)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Line monitor: every level must hold for DIV cycles; data bytes come from exp_q.
    initial begin : line_monitor
        logic [9:0] lvl;
        logic [7:0] want;
        bit held_ok, aborted;
        forever begin
            @(negedge clk);
            if (rst_n === 1'b1 && tx_o === 1'b0) begin
                frames_started++;
                held_ok = 1'b1;
                aborted = 1'b0;
                lvl = '0;
                for (int i = 0; i < 10*DIV; i++) begin
                    if (i > 0) @(negedge clk);
                    if (rst_n !== 1'b1) begin
                        aborted = 1'b1;
                        break;
                    end
                    if (i % DIV == 0) lvl[i/DIV] = tx_o;
                    else if (tx_o !== lvl[i/DIV]) held_ok = 1'b0;
                end
                if (!aborted) begin
                    last_end = cyc;
                    frames_done++;
                    n_cmp++;
                    if (!held_ok) begin
                        n_err++;
                        $display("[TB] FAIL frame_bit_hold: got levels %b, each expected held %0d cycles", lvl, DIV);
                    end
                    n_cmp++;
                    if (lvl[9] !== 1'b1) begin
                        n_err++;
                        $display("[TB] FAIL frame_stop_bit: got %b expected 1", lvl[9]);
                    end
                    n_cmp++;
                    if (exp_q.size() == 0) begin
                        n_err++;
                        $display("[TB] FAIL frame_unexpected: got byte %h expected no frame", lvl[8:1]);
                    end else begin
                        want = exp_q.pop_front();
                        if (lvl[8:1] !== want) begin
                            n_err++;
                            $display("[TB] FAIL frame_data: got %h expected %h", lvl[8:1], want);
                        end
                    end
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_to(input int target);
        int t = 0;
        while (cyc < target && t < 2000) begin
            tick();
            t++;
        end
    endtask

    task automatic wait_idle(input string name);
        int t = 0;
        while (!(tx_empty_o === 1'b1 && exp_q.size() == 0) && t < 3000) begin
            tick();
            t++;
        end
        n_cmp++;
        if (t >= 3000) begin
            n_err++;
            $display("[TB] FAIL %s_idle_timeout: got tx_empty=%b queue=%0d expected 1/0", name, tx_empty_o, exp_q.size());
        end
    endtask

    // resp is -1 when bvalid was not present one cycle after accept.
    task automatic axi_write(input logic [31:0] addr, input logic [31:0] data,
                             input logic [3:0] strb, output int resp, output int acc);
        int t = 0;
        tick();
        s_awaddr = addr; s_wdata = data; s_wstrb = strb;
        s_awvalid = 1'b1; s_wvalid = 1'b1; s_bready = 1'b1;
        #1;
        while (!(s_awready && s_wready) && t < 50) begin
            tick();
            t++;
        end
        if (t >= 50) begin
            n_cmp++; n_err++;
            $display("[TB] FAIL write_accept_timeout: addr %h got no awready expected accept", addr);
            s_awvalid = 1'b0; s_wvalid = 1'b0;
            resp = -1; acc = -1;
            return;
        end
        acc = cyc;
        tick();
        s_awvalid = 1'b0; s_wvalid = 1'b0;
        resp = s_bvalid ? int'(s_bresp) : -1;
    endtask

    task automatic axi_read(input logic [31:0] addr, output logic [31:0] data,
                            output int resp);
        int t = 0;
        tick();
        s_araddr = addr; s_arvalid = 1'b1; s_rready = 1'b1;
        #1;
        while (!s_arready && t < 50) begin
            tick();
            t++;
        end
        if (t >= 50) begin
            n_cmp++; n_err++;
            $display("[TB] FAIL read_accept_timeout: addr %h got no arready expected accept", addr);
            s_arvalid = 1'b0;
            resp = -1; data = '0;
            return;
        end
        tick();
        s_arvalid = 1'b0;
        resp = s_rvalid ? int'(s_rresp) : -1;
        data = s_rdata;
    endtask

    task automatic test_reset();
        logic [31:0] d;
        int r;
        repeat (3) tick();
        n_cmp++;
        if ({tx_o, tx_empty_o} !== 2'b11) begin
            n_err++;
            $display("[TB] FAIL reset_line: got tx/empty %b expected 11", {tx_o, tx_empty_o});
        end
        n_cmp++;
        if ({s_awready, s_wready, s_arready, s_bvalid, s_rvalid} !== 5'b0) begin
            n_err++;
            $display("[TB] FAIL reset_handshake: got %b expected 00000",
                     {s_awready, s_wready, s_arready, s_bvalid, s_rvalid});
        end
        n_cmp++;
        if ({s_bresp, s_rresp, s_rdata} !== 36'h0) begin
            n_err++;
            $display("[TB] FAIL reset_payload: got %h expected 0", {s_bresp, s_rresp, s_rdata});
        end
        rst_n = 1'b1;
        axi_read(32'h4, d, r);
        n_cmp++;
        if (r !== 0 || d !== 32'h2) begin
            n_err++;
            $display("[TB] FAIL reset_status: got resp %0d data %h expected 0 / 00000002", r, d);
        end
    endtask

    task automatic test_single_frame();
        int r, acc, done0;
        done0 = frames_done;
        exp_q.push_back(8'h41);
        axi_write(32'h0, 32'h41, 4'h1, r, acc);
        n_cmp++;
        if (r !== 0) begin
            n_err++;
            $display("[TB] FAIL single_bresp: got %0d expected 0 (bvalid one cycle after accept)", r);
        end
        n_cmp++;
        if (tx_o !== 1'b1) begin
            n_err++;
            $display("[TB] FAIL single_tx_early: got %b expected 1 at accept+1", tx_o);
        end
        tick();
        n_cmp++;
        if (tx_o !== 1'b0) begin
            n_err++;
            $display("[TB] FAIL single_tx_fall: got %b expected 0 at accept+2", tx_o);
        end
        wait_to(acc + 101);
        n_cmp++;
        if (tx_empty_o !== 1'b0) begin
            n_err++;
            $display("[TB] FAIL single_empty_busy: got %b expected 0 at accept+101", tx_empty_o);
        end
        tick();
        n_cmp++;
        if (tx_empty_o !== 1'b1 || frames_done !== done0 + 1) begin
            n_err++;
            $display("[TB] FAIL single_empty_done: got empty %b frames %0d expected 1 / %0d",
                     tx_empty_o, frames_done - done0, 1);
        end
    endtask

    task automatic test_back_to_back();
        int r, acc, acc0, done0, started0, t;
        wait_idle("b2b_pre");
        done0 = frames_done;
        acc0 = 0;
        for (int i = 0; i < 6; i++) begin
            if (i < 5) exp_q.push_back(8'h30 + 8'(i));
            axi_write(32'h0, 32'h30 + i, 4'h1, r, acc);
            if (i == 0) acc0 = acc;
            n_cmp++;
            if (r !== (i < 5 ? 0 : 2)) begin
                n_err++;
                $display("[TB] FAIL b2b_bresp_%0d: got %0d expected %0d", i, r, (i < 5 ? 0 : 2));
            end
        end
        t = 0;
        while (frames_done < done0 + 5 && t < 700) begin
            tick();
            t++;
        end
        n_cmp++;
        if (frames_done !== done0 + 5 || last_end !== acc0 + 501) begin
            n_err++;
            $display("[TB] FAIL b2b_span: got frames %0d end %0d expected 5 / %0d",
                     frames_done - done0, last_end - acc0, 501);
        end
        started0 = frames_started;
        repeat (30) tick();
        n_cmp++;
        if (frames_started !== started0 || tx_empty_o !== 1'b1 || exp_q.size() != 0) begin
            n_err++;
            $display("[TB] FAIL b2b_dropped: got extra %0d empty %b queue %0d expected 0 / 1 / 0",
                     frames_started - started0, tx_empty_o, exp_q.size());
        end
    endtask

    task automatic test_status();
        int r, acc;
        logic [31:0] d;
        wait_idle("status_pre");
        exp_q.push_back(8'hC3);
        axi_write(32'h0, 32'hC3, 4'h1, r, acc);
        repeat (20) tick();
        for (int i = 0; i < 3; i++) begin
            exp_q.push_back(8'h61 + 8'(i));
            axi_write(32'h0, 32'h61 + i, 4'h1, r, acc);
        end
        axi_read(32'h4, d, r);
        n_cmp++;
        if (r !== 0 || d !== 32'h0000_0304) begin
            n_err++;
            $display("[TB] FAIL status_busy: got resp %0d data %h expected 0 / 00000304", r, d);
        end
        wait_idle("status_drain");
    endtask

    task automatic test_unmapped();
        int r, acc, started0;
        logic [31:0] d;
        wait_idle("unmapped_pre");
        started0 = frames_started;
        axi_write(32'h8, 32'h55, 4'hF, r, acc);
        n_cmp++;
        if (r !== 2) begin
            n_err++;
            $display("[TB] FAIL unmapped_wr8: got %0d expected 2", r);
        end
        axi_write(32'hC, 32'h55, 4'hF, r, acc);
        n_cmp++;
        if (r !== 2) begin
            n_err++;
            $display("[TB] FAIL unmapped_wrC: got %0d expected 2", r);
        end
        axi_write(32'h4, 32'h55, 4'hF, r, acc);
        n_cmp++;
        if (r !== 0) begin
            n_err++;
            $display("[TB] FAIL status_write: got %0d expected 0", r);
        end
        axi_write(32'h0, 32'h55, 4'hE, r, acc);
        n_cmp++;
        if (r !== 0) begin
            n_err++;
            $display("[TB] FAIL nostrobe_write: got %0d expected 0", r);
        end
        axi_read(32'h8, d, r);
        n_cmp++;
        if (r !== 2 || d !== 32'h0) begin
            n_err++;
            $display("[TB] FAIL unmapped_rd8: got resp %0d data %h expected 2 / 0", r, d);
        end
        axi_read(32'h0, d, r);
        n_cmp++;
        if (r !== 0 || d !== 32'h0) begin
            n_err++;
            $display("[TB] FAIL txdata_read: got resp %0d data %h expected 0 / 0", r, d);
        end
        axi_read(32'h4, d, r);
        n_cmp++;
        if (r !== 0 || d !== 32'h2) begin
            n_err++;
            $display("[TB] FAIL unmapped_status: got resp %0d data %h expected 0 / 00000002", r, d);
        end
        repeat (30) tick();
        n_cmp++;
        if (frames_started !== started0) begin
            n_err++;
            $display("[TB] FAIL unmapped_no_frame: got %0d frames expected 0", frames_started - started0);
        end
    endtask

    task automatic test_stall();
        int t;
        wait_idle("stall_pre");
        tick();
        s_awaddr = 32'h8; s_wdata = 32'h77; s_wstrb = 4'hF;
        s_awvalid = 1'b1; s_wvalid = 1'b1; s_bready = 1'b0;
        #1;
        t = 0;
        while (!s_awready && t < 50) begin
            tick();
            t++;
        end
        for (int k = 0; k < 5; k++) begin
            tick();
            n_cmp++;
            if (s_bvalid !== 1'b1 || s_bresp !== 2'b10 || s_awready !== 1'b0 || s_wready !== 1'b0) begin
                n_err++;
                $display("[TB] FAIL bstall_%0d: got bvalid %b bresp %b awready %b wready %b expected 1 10 0 0",
                         k, s_bvalid, s_bresp, s_awready, s_wready);
            end
        end
        s_awvalid = 1'b0; s_wvalid = 1'b0; s_bready = 1'b1;
        tick();
        n_cmp++;
        if (s_bvalid !== 1'b0) begin
            n_err++;
            $display("[TB] FAIL bstall_release: got bvalid %b expected 0", s_bvalid);
        end

        tick();
        s_araddr = 32'h4; s_arvalid = 1'b1; s_rready = 1'b0;
        #1;
        t = 0;
        while (!s_arready && t < 50) begin
            tick();
            t++;
        end
        tick();
        // A TXDATA write lands during the stall so a resampled STATUS would differ.
        exp_q.push_back(8'h5A);
        s_awaddr = 32'h0; s_wdata = 32'h5A; s_wstrb = 4'h1;
        s_awvalid = 1'b1; s_wvalid = 1'b1;
        for (int k = 0; k < 5; k++) begin
            if (k == 1) begin
                s_awvalid = 1'b0;
                s_wvalid = 1'b0;
            end
            n_cmp++;
            if (s_rvalid !== 1'b1 || s_rdata !== 32'h2 || s_rresp !== 2'b00 || s_arready !== 1'b0) begin
                n_err++;
                $display("[TB] FAIL rstall_%0d: got rvalid %b rdata %h rresp %b arready %b expected 1 00000002 00 0",
                         k, s_rvalid, s_rdata, s_rresp, s_arready);
            end
            tick();
        end
        s_arvalid = 1'b0; s_rready = 1'b1;
        tick();
        n_cmp++;
        if (s_rvalid !== 1'b0) begin
            n_err++;
            $display("[TB] FAIL rstall_release: got rvalid %b expected 0", s_rvalid);
        end
        wait_idle("stall_drain");
    endtask

    task automatic test_reset_mid_frame();
        int r, acc, done0, started0;
        logic [31:0] d;
        wait_idle("rst_pre");
        exp_q.push_back(8'hA5);
        exp_q.push_back(8'h3C);
        axi_write(32'h0, 32'hA5, 4'h1, r, acc);
        axi_write(32'h0, 32'h3C, 4'h1, r, acc);
        wait_to(acc + 45);
        done0 = frames_done;
        #1;
        rst_n = 1'b0;
        #1;
        n_cmp++;
        if (tx_o !== 1'b1 || tx_empty_o !== 1'b1) begin
            n_err++;
            $display("[TB] FAIL rst_async: got tx %b empty %b expected 1 1", tx_o, tx_empty_o);
        end
        exp_q.delete();
        tick();
        tick();
        rst_n = 1'b1;
        started0 = frames_started;
        axi_read(32'h4, d, r);
        n_cmp++;
        if (r !== 0 || d !== 32'h2) begin
            n_err++;
            $display("[TB] FAIL rst_status: got resp %0d data %h expected 0 / 00000002", r, d);
        end
        repeat (30) tick();
        n_cmp++;
        if (frames_started !== started0 || frames_done !== done0) begin
            n_err++;
            $display("[TB] FAIL rst_discard: got new frames %0d done %0d expected 0 / 0",
                     frames_started - started0, frames_done - done0);
        end
    endtask

    initial begin
        test_reset();
        test_single_frame();
        test_back_to_back();
        test_status();
        test_unmapped();
        test_stall();
        test_reset_mid_frame();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("[TB] FAIL watchdog: got no completion expected finish before 2 ms");
        $fatal(1, "[TB] watchdog expired");
    end

endmodule

// File: doc/axi_uart_tx.md
# axi_uart_tx

AXI4-Lite slave stdout transmitter inside `axi_subsystem`. It sits directly upstream of the testbench `uart` receiver and drives the subsystem `tx_o` line. The core writes bytes into a TX FIFO over AXI4-Lite. The block serialises them as 8N1 frames at a fixed baud rate and exposes FIFO and busy status through a readable register.

## Interface
Parameters:
- `CLK_FREQ`, 100_000_000: clock frequency in Hz.
- `BAUD`, 57600: line rate. Bit period `DIV = CLK_FREQ / BAUD`, integer floor, must be ≥ 2.
- `FIFO_DEPTH`, 16: TX FIFO entries, power of two, 2..256.

Ports:
- `clk`  in  1  clock.
- `rst_n`  in  1  reset, asynchronous, active-low.
- `s_awvalid` / `s_awready`  in/out  1  write-address handshake.
- `s_awaddr`  in  32  write address; only bits [3:2] are decoded.
- `s_wvalid` / `s_wready`  in/out  1  write-data handshake.
- `s_wdata`  in  32  write data.
- `s_wstrb`  in  4  byte strobes.
- `s_bvalid` / `s_bready`  out/in  1  write-response handshake.
- `s_bresp`  out  2  write response code.
- `s_arvalid` / `s_arready`  in/out  1  read-address handshake.
- `s_araddr`  in  32  read address; only bits [3:2] are decoded.
- `s_rvalid` / `s_rready`  out/in  1  read-data handshake.
- `s_rdata`  out  32  read data.
- `s_rresp`  out  2  read response code.
- `tx_o`  out  1  serial output, idles high.
- `tx_empty_o`  out  1  FIFO empty and serializer idle.

## Operation
Register map, decoded on `addr[3:2]`:
- `0x0` TXDATA. Write pushes `wdata[7:0]` when `wstrb[0]=1`. Read returns 0.
- `0x4` STATUS, read-only. Bit 0 = full, bit 1 = empty, bit 2 = busy (serializer not IDLE), bits [16:8] = FIFO count, others 0. Writes are ignored and return OKAY.
- `0x8` and `0xC` are unmapped. Reads and writes return SLVERR (2'b10); reads return `rdata=0`.

Write channel:
- One write outstanding at a time.
- `s_awready` and `s_wready` are asserted together, for one cycle, only when `s_awvalid && s_wvalid && !s_bvalid`.
- TXDATA write with FIFO full: byte dropped, `bresp=SLVERR`. Otherwise `bresp=OKAY`.
- TXDATA write with `wstrb[0]=0`: no push, OKAY.

Read channel:
- One read outstanding at a time.
- `s_arready` is pulsed when `s_arvalid && !s_rvalid`.
- STATUS is sampled in the accept cycle.

FIFO:
- Circular buffer; pointers are log2(`FIFO_DEPTH`)+1 bits wide with a wrap bit, so full and empty are distinguishable.
- Push and pop in the same cycle are allowed when the FIFO is non-full and non-empty; count is unchanged.
- Push is qualified against the full flag of the current cycle. A push on full is rejected even if a pop occurs in the same cycle.

Serializer FSM (bit counter 0..7, baud counter 0..DIV-1):
- IDLE: if FIFO non-empty, pop into the shift register and go to START.
- START: `tx_o=0` for DIV cycles, then DATA.
- DATA: `tx_o=shift[0]`, LSB first, shifting every DIV cycles. After bit 7 go to STOP.
- STOP: `tx_o=1` for DIV cycles. At the end, pop and go to START if the FIFO is non-empty, otherwise go to IDLE. There are no idle cycles between back-to-back frames.
- Frame length is exactly 10·DIV cycles.

## Timing
Reset values:
- `tx_o=1`, `tx_empty_o=1`.
- All `*ready`=0, `s_bvalid`=0, `s_rvalid`=0.
- `s_bresp`=0, `s_rresp`=0, `s_rdata`=0.
- FIFO empty, FSM in IDLE.

Latencies:
- Write accepted in cycle N: FIFO count updates at N+1, `s_bvalid`=1 from N+1 and held until `s_bready`.
- Read accepted in cycle N: `s_rvalid`=1 from N+1 with `rdata`/`rresp` stable until `s_rready`.
- Push at N into an idle serializer: pop at N+1, `tx_o` falls at N+2.
- `tx_o` is registered, so there are no glitches.

Reset mid-operation: asynchronous assertion aborts the frame; `tx_o` returns high immediately and FIFO contents are discarded.

## Test plan
All scenarios use `CLK_FREQ=1_000_000`, `BAUD=100_000` (DIV=10) and `FIFO_DEPTH=4`.
- Reset, then write 0x41 to 0x0: BRESP=OKAY one cycle after accept. `tx_o` falls 2 cycles after accept and carries 0,1,0,0,0,0,0,1,0,1, each level held 10 cycles. `tx_empty_o` returns to 1 after 100 cycles.
- Write 6 bytes back-to-back while the first is transmitting: the first 5 return OKAY (1 in serializer + 4 in FIFO), the 6th returns SLVERR and is absent from the line. Frames are contiguous, 500 cycles total.
- Read 0x4 after pushing 3 bytes during an active frame: rdata=0x0000_0304 (count 3, busy).
- Accesses to 0x8: write returns BRESP=SLVERR; read returns RRESP=SLVERR, rdata=0. FIFO is unchanged.
- Hold `s_bready`/`s_rready` low for 5 cycles: the valid signal and payload stay stable, and no new AW/W/AR is accepted meanwhile.
- Assert `rst_n` low mid-DATA: `tx_o`=1 in the same cycle. After release, STATUS reads 0x0000_0002.
